drec_btn_cond: RTL and testbench

- Conditions the two raw front-panel buttons (Play, Record) for the recorder controller.
- Per button: 2-flop synchroniser, counter-based debounce, 4-state press/release FSM.
- Emits a one-cycle press pulse per physical press and a debounced level per button.
- Sits directly upstream of the controller's play_btn/rec_btn inputs. Takes the controller's btn_rst as a flush.

---
 rtl/drec_btn_cond.sv | 169 ++++++++++++++++
 tb/tb_drec_btn_cond.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/drec_btn_cond.sv
// rtl/drec_btn_cond.sv - Play/Record button synchroniser, debouncer and press-pulse generator

// One button channel: 2-flop synchroniser, debounce counter and press/release FSM.
module drec_btn_chan #(
  parameter int DEBOUNCE_CYCLES = 11000,
  parameter int CNT_W           = 14,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic flush,
  output logic req,
  output logic level
);

  typedef enum logic [1:0] {
    REL        = 2'd0,
    PRESS_WAIT = 2'd1,
    PRESSED    = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  // Pin value seen while the button is not pressed.
  localparam logic RELEASED_PIN = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic s1;
  logic s2;
  logic pressed;
  state_t state;
  state_t state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign pressed = s2 ^ RELEASED_PIN;

  // Two-flop synchroniser for the asynchronous pin; resets to the released level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= RELEASED_PIN;
      s2 <= RELEASED_PIN;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // State, counter and registered debounced level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= REL;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= (state_nxt == PRESSED) || (state_nxt == REL_WAIT);
    end
  end

  // Next-state logic; a flush only aborts a press still being debounced.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req       = 1'b0;
    case (state)
      REL: begin
        if (pressed) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (flush || !pressed) begin
          state_nxt = REL;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          req       = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_nxt = REL_WAIT;
          cnt_nxt   = '0;
        end
      end
      REL_WAIT: begin
        if (pressed) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = REL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = REL;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// Two conditioned channels with Play-priority pulse arbitration.
module drec_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 11000,
  parameter int CNT_W           = 14,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic play_raw,
  input  logic rec_raw,
  input  logic btn_rst,
  output logic play_btn,
  output logic rec_btn,
  output logic play_level,
  output logic rec_level
);

  logic play_req;
  logic rec_req;

  drec_btn_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_play (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (play_raw),
    .flush(btn_rst),
    .req  (play_req),
    .level(play_level)
  );

  drec_btn_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_rec (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (rec_raw),
    .flush(btn_rst),
    .req  (rec_req),
    .level(rec_level)
  );

  // Registered pulses; a simultaneous Record request loses to Play and is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      play_btn <= 1'b0;
      rec_btn  <= 1'b0;
    end else begin
      play_btn <= play_req & ~btn_rst;
      rec_btn  <= rec_req & ~play_req & ~btn_rst;
    end
  end

endmodule

// File: tb/tb_drec_btn_cond.sv
// tb/tb_drec_btn_cond.sv - scoreboard bench for drec_btn_cond, both pin polarities

module tb_drec_btn_cond;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_rst = 1'b0;
  logic play_p = 1'b0;
  logic rec_p = 1'b0;
  logic play_raw_l, rec_raw_l, play_raw_h, rec_raw_h;
  logic pb_l, rb_l, pl_l, rl_l;
  logic pb_h, rb_h, pl_h, rl_h;

  assign play_raw_l = ~play_p;
  assign rec_raw_l  = ~rec_p;
  assign play_raw_h = play_p;
  assign rec_raw_h  = rec_p;

  always #5 clk = ~clk;

  drec_btn_cond #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .ACTIVE_LOW(1)) u_dut_l (
    .clk(clk), .rst_n(rst_n), .play_raw(play_raw_l), .rec_raw(rec_raw_l),
    .btn_rst(btn_rst), .play_btn(pb_l), .rec_btn(rb_l),
    .play_level(pl_l), .rec_level(rl_l)
  );

  drec_btn_cond #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .ACTIVE_LOW(0)) u_dut_h (
    .clk(clk), .rst_n(rst_n), .play_raw(play_raw_h), .rec_raw(rec_raw_h),
    .btn_rst(btn_rst), .play_btn(pb_h), .rec_btn(rb_h),
    .play_level(pl_h), .rec_level(rl_h)
  );

  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  bit started = 0;
  int pulses_play = 0;
  int pulses_rec = 0;

  // Reference model: a debounced level flips after D+1 consecutive disagreeing
  // synchronised samples; a flush drops a pending press run.
  initial begin : model
    bit acc[2];
    int run[2];
    bit s1[2];
    bit s2[2];
    bit p[2];
    bit rise[2];
    for (int c = 0; c < 2; c++) begin
      acc[c] = 0; run[c] = 0; s1[c] = 0; s2[c] = 0;
    end
    forever begin
      @(posedge clk);
      p[0] = play_p;
      p[1] = rec_p;
      if (!rst_n) begin
        for (int c = 0; c < 2; c++) begin
          acc[c] = 0; run[c] = 0; s1[c] = 0; s2[c] = 0; rise[c] = 0;
        end
      end else begin
        for (int c = 0; c < 2; c++) begin
          rise[c] = 0;
          if (btn_rst && !acc[c] && run[c] >= 1) begin
            run[c] = 0;
          end else if (s2[c] != acc[c]) begin
            run[c]++;
            if (run[c] == D + 1) begin
              acc[c] = ~acc[c];
              run[c] = 0;
              rise[c] = acc[c];
            end
          end else begin
            run[c] = 0;
          end
          s2[c] = s1[c];
          s1[c] = p[c];
        end
      end
      exp_q.push_back({rise[0], rise[1] & ~rise[0], acc[0], acc[1]});
      started = 1;
    end
  end

  task automatic chk(input string name, input logic act, input logic req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
  endtask

  // Monitor: pops one expected output word per cycle and compares both DUTs.
  initial begin : monitor
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[3]) pulses_play++;
        if (e[2]) pulses_rec++;
        chk("play_btn_al1", pb_l, e[3]);
        chk("rec_btn_al1", rb_l, e[2]);
        chk("play_level_al1", pl_l, e[1]);
        chk("rec_level_al1", rl_l, e[0]);
        chk("play_btn_al0", pb_h, e[3]);
        chk("rec_btn_al0", rb_h, e[2]);
        chk("play_level_al0", pl_h, e[1]);
        chk("rec_level_al0", rl_h, e[0]);
        chk("pulse_exclusive", pb_l & rb_l, 1'b0);
      end else if (started) begin
        chk("scoreboard_underrun", 1'b1, 1'b0);
      end
    end
  end

  task automatic drive(input bit pp, input bit rp, input bit fl, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      play_p  = pp;
      rec_p   = rp;
      btn_rst = fl;
    end
  endtask

  initial begin : stim
    int np, nr;
    drive(0, 0, 0, 3);
    @(posedge clk); #2; rst_n = 1'b1;
    drive(0, 0, 0, 6);
    // clean press and release of Play
    drive(1, 0, 0, 40);
    drive(0, 0, 0, 12);
    // bouncing Record then a solid hold
    drive(0, 1, 0, 3); drive(0, 0, 0, 2); drive(0, 1, 0, 3); drive(0, 0, 0, 4);
    drive(0, 1, 0, 10); drive(0, 0, 0, 12);
    // simultaneous press
    drive(1, 1, 0, 20); drive(0, 0, 0, 12);
    // flush during the press wait, then flush on the request edge
    drive(1, 0, 0, 4); drive(1, 0, 1, 1); drive(1, 0, 0, 15); drive(0, 0, 0, 12);
    drive(1, 0, 0, 6); drive(1, 0, 1, 1); drive(1, 0, 0, 15); drive(0, 0, 0, 12);
    // long hold, short release, long release
    drive(1, 0, 0, 100); drive(0, 0, 0, 2); drive(1, 0, 0, 10);
    drive(0, 0, 0, 10); drive(1, 0, 0, 10); drive(0, 0, 0, 12);
    // reset while Play is held
    drive(1, 0, 0, 15);
    @(posedge clk); #2; rst_n = 1'b0;
    @(posedge clk); #2; rst_n = 1'b1;
    drive(1, 0, 0, 15); drive(0, 0, 0, 12);
    // randomised segments
    for (int k = 0; k < 400; k++) begin
      np = $urandom_range(1, 12);
      drive($urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 9) == 0), np);
      if ($urandom_range(0, 49) == 0) begin
        @(posedge clk); #2; rst_n = 1'b0;
        @(posedge clk); #2; rst_n = 1'b1;
      end
    end
    nr = 0;
    drive(0, 0, 0, 12);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() <= 1) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected <=1", exp_q.size());
    n_checks++;
    if (pulses_play > 5 && pulses_rec > 0) n_pass++;
    else $display("FAIL pulse_coverage: got play=%0d rec=%0d expected play>5 rec>0",
                  pulses_play, pulses_rec + nr);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
